// File: rtl/data_mem_pkg.sv
// Shared encodings, FSM state type and load extraction for the sized data memory
// and the core's writeback path.
package data_mem_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } mem_state_e;

  // Pulls the addressed byte/half out of a little-endian word and extends it.
  function automatic logic [31:0] load_extend(
    input logic [31:0] word,
    input logic [1:0]  offset,
    input logic [1:0]  size,
    input logic        is_unsigned
  );
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] result;
    case (offset)
      2'd0:    byte_val = word[7:0];
      2'd1:    byte_val = word[15:8];
      2'd2:    byte_val = word[23:16];
      default: byte_val = word[31:24];
    endcase
    half_val = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: result = {{24{byte_val[7] & ~is_unsigned}}, byte_val};
      SIZE_HALF: result = {{16{half_val[15] & ~is_unsigned}}, half_val};
      default:   result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/data_mem_lane_align.sv
// Combinational lane steering: store byte-enables/replicated data and load
// extraction with sign/zero extension.
module data_mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_offset_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_data_o,
  input  logic [31:0] ld_word_i,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_offset_i,
  input  logic        ld_unsigned_i,
  output logic [31:0] ld_data_o
);

  // Store data is replicated across lanes so each lane only needs its enable.
  always_comb begin
    st_be_o   = 4'b0000;
    st_data_o = st_data_i;
    case (st_size_i)
      SIZE_BYTE: begin
        st_be_o   = 4'b0001 << st_offset_i;
        st_data_o = {4{st_data_i[7:0]}};
      end
      SIZE_HALF: begin
        st_be_o   = st_offset_i[1] ? 4'b1100 : 4'b0011;
        st_data_o = {2{st_data_i[15:0]}};
      end
      SIZE_WORD: begin
        st_be_o   = 4'b1111;
        st_data_o = st_data_i;
      end
      default: begin
        st_be_o   = 4'b0000;
        st_data_o = st_data_i;
      end
    endcase
  end

  always_comb begin
    ld_data_o = load_extend(ld_word_i, ld_offset_i, ld_size_i, ld_unsigned_i);
  end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed data memory with sized, extended loads, registered read path,
// access checking with a saturating error counter, and a post-reset clear sweep.
module data_memory_sized
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DEPTH         = 256,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_WIDTH-1:0]    address,
  input  logic [31:0]              write_data,
  input  logic                     mem_write,
  input  logic                     mem_read,
  input  logic [1:0]               mem_size,
  input  logic                     mem_unsigned,
  output logic [31:0]              read_data,
  output logic                     read_valid,
  output logic                     ready,
  output logic                     err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int IDX_W = $clog2(DEPTH);

  mem_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sweep_we;
  logic             ready_q;

  logic [ADDR_WIDTH-3:0] word_addr;
  logic [IDX_W-1:0]      req_idx;
  logic req_any, conflict, size_bad, misaligned, out_of_range;
  logic reject, accept_ld, accept_st;

  logic [3:0]       st_be;
  logic [31:0]      st_data;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;

  logic [31:0] rd_word;
  logic [1:0]  ld_size_q, ld_offset_q;
  logic        ld_unsigned_q;
  logic        read_valid_q;
  logic        err_q;
  logic [ERR_CNT_WIDTH-1:0] err_count_q;

  // Request decode; all reject causes behave identically, so their order is moot.
  always_comb begin
    word_addr    = address[ADDR_WIDTH-1:2];
    req_idx      = word_addr[IDX_W-1:0];
    req_any      = ready_q & (mem_read | mem_write);
    conflict     = mem_read & mem_write;
    size_bad     = (mem_size == SIZE_ILLEGAL);
    misaligned   = ((mem_size == SIZE_HALF) && address[0]) ||
                   ((mem_size == SIZE_WORD) && (address[1:0] != 2'b00));
    out_of_range = ((word_addr >> IDX_W) != '0);
    reject       = req_any & (conflict | size_bad | misaligned | out_of_range);
    accept_ld    = req_any & ~reject & mem_read;
    accept_st    = req_any & ~reject & mem_write;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= (state_q == READY);
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sweep_we = 1'b0;
    case (state_q)
      INIT: begin
        sweep_we = 1'b1;
        if (idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = READY;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  data_mem_lane_align u_lane_align (
    .st_size_i     (mem_size),
    .st_offset_i   (address[1:0]),
    .st_data_i     (write_data),
    .st_be_o       (st_be),
    .st_data_o     (st_data),
    .ld_word_i     (rd_word),
    .ld_size_i     (ld_size_q),
    .ld_offset_i   (ld_offset_q),
    .ld_unsigned_i (ld_unsigned_q),
    .ld_data_o     (read_data)
  );

  // The clear sweep and accepted stores share the single write port.
  always_comb begin
    wr_en   = rst_n & (sweep_we | accept_st);
    wr_idx  = sweep_we ? idx_q : req_idx;
    wr_be   = sweep_we ? 4'hF : st_be;
    wr_data = sweep_we ? 32'h0 : st_data;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] rd_byte_q;

    always_ff @(posedge clk) begin
      if (wr_en && wr_be[gi]) begin
        lane_mem[wr_idx] <= wr_data[8*gi +: 8];
      end
    end

    // Read register only loads on an accepted load, so read_data holds otherwise.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_byte_q <= '0;
      end else if (accept_ld) begin
        rd_byte_q <= lane_mem[req_idx];
      end
    end

    assign rd_word[8*gi +: 8] = rd_byte_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_size_q     <= SIZE_WORD;
      ld_offset_q   <= 2'b00;
      ld_unsigned_q <= 1'b0;
      read_valid_q  <= 1'b0;
      err_q         <= 1'b0;
      err_count_q   <= '0;
    end else begin
      if (accept_ld) begin
        ld_size_q     <= mem_size;
        ld_offset_q   <= address[1:0];
        ld_unsigned_q <= mem_unsigned;
      end
      read_valid_q <= accept_ld;
      err_q        <= reject;
      if (reject && (err_count_q != '1)) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign read_valid = read_valid_q;
  assign err        = err_q;
  assign err_count  = err_count_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: directed sized stores/loads, error
// cases, saturation and reset/sweep timing.
module tb_data_memory_sized;

  localparam int ADDR_WIDTH    = 32;
  localparam int DEPTH         = 256;
  localparam int ERR_CNT_WIDTH = 8;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [ADDR_WIDTH-1:0] address = '0;
  logic [31:0] write_data = '0;
  logic mem_write = 1'b0;
  logic mem_read = 1'b0;
  logic [1:0] mem_size = 2'b10;
  logic mem_unsigned = 1'b0;
  logic [31:0] read_data;
  logic read_valid;
  logic ready;
  logic err;
  logic [ERR_CNT_WIDTH-1:0] err_count;

  data_memory_sized #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH(DEPTH),
    .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .address(address),
    .write_data(write_data),
    .mem_write(mem_write),
    .mem_read(mem_read),
    .mem_size(mem_size),
    .mem_unsigned(mem_unsigned),
    .read_data(read_data),
    .read_valid(read_valid),
    .ready(ready),
    .err(err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [31:0] data;
    int          due;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int txn = 0;

  always @(posedge clk) cyc++;

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_response txn=%0d actual=none required=%s at cycle %0d",
               sb[0].id, sb[0].is_err ? "err" : "read_valid", sb[0].due);
      void'(sb.pop_front());
    end
    if (read_valid === 1'b1 || err === 1'b1) begin
      checks++;
      if (sb.size() == 0 || sb[0].due != cyc) begin
        failures++;
        $display("FAIL unexpected_response cycle=%0d actual read_valid=%b err=%b data=%h required=none",
                 cyc, read_valid, err, read_data);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_err) begin
          if (err !== 1'b1 || read_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_txn%0d actual err=%b read_valid=%b required err=1 read_valid=0",
                     mon_e.id, err, read_valid);
          end else begin
            $display("txn %0d rejected as expected, err_count=%0d", mon_e.id, err_count);
          end
        end else begin
          if (read_valid !== 1'b1 || err !== 1'b0 || read_data !== mon_e.data) begin
            failures++;
            $display("FAIL load_txn%0d actual valid=%b err=%b data=%h required valid=1 err=0 data=%h",
                     mon_e.id, read_valid, err, read_data, mon_e.data);
          end else begin
            $display("txn %0d load data=%h", mon_e.id, read_data);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("check %s = %h", name, act);
    end
  endtask

  task automatic idle();
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_size = SZ_W;
    mem_unsigned = 1'b0;
    address = '0;
    write_data = '0;
  endtask

  // Drives one request for one cycle; loads and rejects queue an expectation.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_data);
    exp_t e;
    mem_read = rd;
    mem_write = wr;
    mem_size = size;
    mem_unsigned = uns;
    address = addr;
    write_data = wdata;
    txn++;
    if (exp_err || rd) begin
      e.is_err = exp_err;
      e.data = exp_data;
      e.due = cyc + 1;
      e.id = txn;
      sb.push_back(e);
    end else begin
      $display("txn %0d store size=%0d addr=%h data=%h", txn, size, addr, wdata);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic st(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] d);
    issue(1'b0, 1'b1, size, 1'b0, addr, d, 1'b0, 32'h0);
  endtask

  task automatic ld(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                    input logic [31:0] exp_data);
    issue(1'b1, 1'b0, size, uns, addr, 32'h0, 1'b0, exp_data);
  endtask

  task automatic bad(input logic rd, input logic wr, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] d);
    issue(rd, wr, size, 1'b0, addr, d, 1'b1, 32'h0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    check({tag, "_read_data"}, read_data, 32'h0);
    check({tag, "_read_valid"}, 32'(read_valid), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_err_count"}, 32'(err_count), 32'h0);
    check({tag, "_ready"}, 32'(ready), 32'h0);
    rst_n = 1'b1;
  endtask

  // Requests during the sweep must be ignored; ready rises DEPTH+1 edges after release.
  task automatic sweep_check(input string tag);
    for (int i = 0; i < DEPTH - 1; i++) begin
      mem_read = 1'b1;
      mem_write = i[0];
      mem_size = SZ_W;
      address = 32'h8;
      write_data = 32'hFFFF_FFFF;
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    check({tag, "_ready_after_DEPTH"}, 32'(ready), 32'h0);
    @(negedge clk);
    check({tag, "_ready_after_DEPTH+1"}, 32'(ready), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    do_reset("reset");
    sweep_check("init");
    ld(SZ_W, 1'b0, 32'h8, 32'h0000_0000);

    st(SZ_W, 32'h4, 32'h1234_5678);
    st(SZ_B, 32'h5, 32'h0000_00AB);
    ld(SZ_W, 1'b0, 32'h4, 32'h1234_AB78);
    ld(SZ_B, 1'b0, 32'h5, 32'hFFFF_FFAB);
    ld(SZ_B, 1'b1, 32'h5, 32'h0000_00AB);
    ld(SZ_H, 1'b0, 32'h6, 32'h0000_1234);
    ld(SZ_H, 1'b0, 32'h4, 32'hFFFF_AB78);
    ld(SZ_H, 1'b1, 32'h4, 32'h0000_AB78);
    ld(SZ_B, 1'b0, 32'h7, 32'h0000_0012);
    st(SZ_H, 32'hA, 32'h0000_BEEF);
    ld(SZ_W, 1'b0, 32'h8, 32'hBEEF_0000);

    st(SZ_W, 32'h3FC, 32'hCAFE_F00D);
    ld(SZ_W, 1'b0, 32'h3FC, 32'hCAFE_F00D);
    ld(SZ_B, 1'b1, 32'h3FF, 32'h0000_00CA);

    st(SZ_W, 32'h8, 32'h8765_4321);
    ld(SZ_W, 1'b0, 32'h8, 32'h8765_4321);
    @(negedge clk);
    check("b2b_valid_one_cycle", 32'(read_valid), 32'h0);
    check("b2b_data_held", read_data, 32'h8765_4321);

    bad(1'b1, 1'b0, SZ_H, 32'h3, 32'h0);
    bad(1'b0, 1'b1, SZ_W, 32'h6, 32'hDEAD_BEEF);
    bad(1'b0, 1'b1, SZ_X, 32'h8, 32'h0);
    bad(1'b1, 1'b1, SZ_W, 32'h4, 32'hFFFF_FFFF);
    bad(1'b0, 1'b1, SZ_W, DEPTH * 4, 32'h5555_5555);
    check("err_count_5", 32'(err_count), 32'd5);
    check("data_held_over_errors", read_data, 32'h8765_4321);
    ld(SZ_W, 1'b0, 32'h4, 32'h1234_AB78);
    ld(SZ_W, 1'b0, 32'h8, 32'h8765_4321);
    ld(SZ_W, 1'b0, 32'h0, 32'h0000_0000);

    for (int i = 0; i < 300; i++) begin
      bad(1'b1, 1'b0, SZ_X, 32'h4, 32'h0);
    end
    check("err_count_saturated", 32'(err_count), 32'h0000_00FF);

    do_reset("reset_after_data");
    repeat (100) @(negedge clk);
    do_reset("reset_mid_sweep");
    sweep_check("resweep");
    ld(SZ_W, 1'b0, 32'h4, 32'h0000_0000);
    ld(SZ_W, 1'b0, 32'h3FC, 32'h0000_0000);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
